// File: rtl/serial_sub_pkg.sv
// Shared state encoding and legal width bounds for the bit-serial subtractor.
package serial_sub_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/fs_bit_cell.sv
// Combinational 1-bit full subtractor formed from two cascaded half subtractors.
module fs_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;

  always_comb begin
    d1   = a ^ b;
    b1   = ~a & b;
    d    = d1 ^ bin;
    b2   = ~d1 & bin;
    bout = b1 | b2;
  end
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B - Bin controller: LSB-first, one bit per clock through fs_bit_cell,
// with start/done handshake and registered result.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  import serial_sub_pkg::*;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("serial_sub_ctrl: WIDTH out of range");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cell_d, cell_bout;
  logic [WIDTH-1:0] d_sh_next;

  fs_bit_cell u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Shift-based insert keeps the WIDTH=1 case legal (no zero-width slices).
  assign d_sh_next = (d_sh_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_sh_d  = d_sh_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          br_d    = bin;
          cnt_d   = '0;
          d_sh_d  = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = cell_bout;
        d_sh_d = d_sh_next;
        if (cnt_q == CNT_LAST) begin
          diff_d  = d_sh_next;
          bout_d  = cell_bout;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_sh_q  <= d_sh_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial subtraction controller. It accepts WIDTH-bit operands and a borrow-in, and computes A − B − Bin LSB-first, one bit per clock, through a single 1-bit full-subtractor cell. The cell is built from two half-subtractor stages. The block sits between a requesting master (start/done handshake) and the 1-bit subtract datapath, and owns operand shifting, borrow propagation, bit counting and result capture.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.
CNT_W, derived as max(1, clog2(WIDTH)), bit-counter width; not user-overridable.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  asynchronous active-low reset; deassertion synchronous to clk externally.
start  input  1  request pulse or level; sampled only in IDLE or DONE.
a_in  input  WIDTH  minuend; captured on accepted start.
b_in  input  WIDTH  subtrahend; captured on accepted start.
bin  input  1  borrow-in; captured on accepted start.
busy  output  1  high while state = RUN.
done  output  1  high for exactly one cycle (state = DONE).
diff  output  WIDTH  result A − B − Bin mod 2^WIDTH; registered.
bout  output  1  final borrow-out; registered.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, diff=0, bout=0. Internal shift registers, borrow flop and counter also clear to 0.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at a rising edge, then:
  - a_sh←a_in, b_sh←b_in, br←bin, cnt←0, d_sh←0.
  - Go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - d = a_sh[0]^b_sh[0]^br
  - br←(~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&br)
  - a_sh, b_sh shift right one bit.
  - d shifts into d_sh MSB.
  - cnt←cnt+1.
- RUN exit: when cnt = WIDTH−1 at the edge, the same edge loads diff←final d_sh (including the current bit) and bout←new br, then goes to DONE.
- DONE: done=1 for one cycle.
  - If start=1 at the edge, it is accepted exactly as in IDLE and the state goes to RUN (back-to-back).
  - Otherwise go to IDLE.
- Latency: start accepted at edge k → busy=1 during cycles k..k+WIDTH−1, with diff/bout valid and done=1 after edge k+WIDTH. Total throughput is WIDTH+1 cycles per operation.
- diff/bout hold their value from the DONE load until the next DONE load. They do not change during a subsequent RUN.
- start while RUN: ignored; no restart, no queueing.
- a_in/b_in/bin changes after acceptance: no effect.
- WIDTH=1: a single RUN cycle; cnt stays 0; the exit condition is true on the first RUN edge.
- Reset mid-RUN: immediate abort to the reset values. The partial result is discarded and done is not asserted.
- Unused/illegal state encoding: next state = IDLE.

Decomposition:
- Package serial_sub_pkg holds:
  - the state enum/localparams (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - the WIDTH bounds constants.
- Sub-module fs_bit_cell: combinational 1-bit full subtractor built from two half-subtractor stages. Inputs a, b, bin; outputs d, bout. The borrow is the OR of the two stage borrows.
- FSM, counter, shift registers and result registers stay in serial_sub_ctrl.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start at edge k → busy 8 cycles; done=1 after edge k+8; diff=0x1E, bout=0.
- WIDTH=8, a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Then a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0.
- start held high in RUN with different a_in → ignored, result matches the originally captured operands. start high during DONE → new operation accepted, busy rises next cycle, prior diff held until the new done.
- rst_n pulsed low at RUN cycle 4 → all outputs 0 asynchronously, no done. A fresh start then completes correctly: 0xFF−0xFF → 0x00, bout=0.
- WIDTH=1 instance, all 8 (a,b,bin) combinations → done 1 cycle after busy. The (diff,bout) pairs are:
  - 000→(0,0)
  - 010→(1,1)
  - 100→(1,0)
  - 110→(0,0)
  - 001→(1,1)
  - 011→(0,1)
  - 101→(0,0)
  - 111→(1,1)
- Randomized WIDTH=8 sweep (≥200 ops, idle gaps 0–3 cycles): diff/bout match the (A−B−Bin) reference model; done pulses are exactly one cycle wide.
